// File: rtl/exp_scale_restore.sv
// exp_scale_restore: rebuilds e^x = 2^k * e^r with an in-order k tag FIFO.
// Define EXP_SCALE_SATURATE_EN to saturate overflow to max finite, not infinity.
module exp_scale_restore #(
  parameter int DEPTH   = 16,
  parameter int K_WIDTH = 9
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     k_valid,
  input  logic [K_WIDTH-1:0]       k_data,
  output logic                     k_ready,
  input  logic                     poly_valid,
  input  logic [31:0]              poly_data,
  output logic                     result_valid,
  output logic [31:0]              result_data,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     tag_error,
  output logic [$clog2(DEPTH):0]   tag_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = K_WIDTH + 2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [EW-1:0] EMAX = EW'(255);

  logic [K_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               err_q;

  logic               s1_valid_q;
  logic               s1_s_q;
  logic [7:0]         s1_e_q;
  logic [22:0]        s1_m_q;
  logic [EW-1:0]      s1_esum_q, esum_d;

  logic               res_valid_q, ovf_q, unf_q;
  logic [31:0]        res_q, res_d;
  logic               ovf_d, unf_d;

  logic push, pop, empty;
  logic [K_WIDTH-1:0] tag;

  assign empty   = (count_q == '0);
  assign k_ready = (count_q != FULL);
  assign push    = k_valid & k_ready;
  assign pop     = poly_valid & ~empty;
  assign tag     = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
  end

  // Exponent zero-extended, k sign-extended, so the sum never wraps.
  assign esum_d = {{(EW-8){1'b0}}, poly_data[30:23]}
                + {{2{tag[K_WIDTH-1]}}, tag};

  always_ff @(posedge clock) begin
    if (push)
      mem_q[wr_ptr_q] <= k_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if ((k_valid && !k_ready) || (poly_valid && empty))
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_e_q     <= '0;
      s1_m_q     <= '0;
      s1_esum_q  <= '0;
    end else begin
      s1_valid_q <= pop;
      if (pop) begin
        s1_s_q    <= poly_data[31];
        s1_e_q    <= poly_data[30:23];
        s1_m_q    <= poly_data[22:0];
        s1_esum_q <= esum_d;
      end
    end
  end

  always_comb begin
    res_d = {s1_s_q, s1_esum_q[7:0], s1_m_q};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s1_e_q == 8'hFF) begin
      res_d = {s1_s_q, s1_e_q, s1_m_q};
    end else if (s1_e_q == 8'h00) begin
      res_d = {s1_s_q, 31'b0};
    end else if (!s1_esum_q[EW-1] && s1_esum_q >= EMAX) begin
      ovf_d = 1'b1;
`ifdef EXP_SCALE_SATURATE_EN
      res_d = {s1_s_q, 8'hFE, 23'h7FFFFF};
`else
      res_d = {s1_s_q, 8'hFF, 23'h0};
`endif
    end else if (s1_esum_q[EW-1] || s1_esum_q == '0) begin
      unf_d = 1'b1;
      res_d = {s1_s_q, 31'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      res_valid_q <= s1_valid_q;
      ovf_q       <= s1_valid_q & ovf_d;
      unf_q       <= s1_valid_q & unf_d;
      if (s1_valid_q)
        res_q <= res_d;
    end
  end

  assign result_valid = res_valid_q;
  assign result_data  = res_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign tag_error    = err_q;
  assign tag_count    = count_q;

endmodule
